// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the clock-enable divider bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: system clock rate, divisors for the standard tick rates, clog2 helper.

package clock_divider_pkg;

   localparam int SYS_CLK_HZ = 100_000_000;

   // Divisors for the legacy fixed outputs at SYS_CLK_HZ
   localparam int DIV_200HZ = 500000;
   localparam int DIV_1KHZ  = 100000;
   localparam int DIV_25MHZ = 4;

   // Smallest width w with 2**w >= v
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/div_channel.sv
// One clock-enable channel: wrapping counter, registered tick strobe and square output.
// Latency: tick/sq are registered, one cycle behind the counter state that produces them.
// Backpressure: none; a divisor write is accepted every cycle (last write wins).
// Ports: i_clk, i_rst_n (async active-low), i_en run enable, i_sync_clr counter clear,
//        i_wr/i_wr_div divisor write, o_tick one-cycle strobe, o_sq square wave.
// Build option DIV_SHADOW_EN: writes are staged and applied only at a period boundary.

module div_channel
   import clock_divider_pkg::*;
#(
   parameter int               CNT_W   = 24,
   parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DIV_25MHZ)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_sync_clr,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_wr_div,
   output logic             o_tick,
   output logic             o_sq
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_div;
   logic [CNT_W-1:0] r_cnt;
   logic             r_tick;
   logic             r_sq;

   logic             w_active;
   logic             w_wrap;
   logic             w_restart;
   logic [CNT_W-1:0] w_half;

   // div = 0 parks the channel exactly like a cleared enable
   assign w_active = i_en && (r_div != '0);
   // ">=" rather than "==" so a divisor shrunk below the held count still wraps
   assign w_wrap   = w_active && (r_cnt >= (r_div - ONE));
   assign w_half   = r_div >> 1;

`ifdef DIV_SHADOW_EN
   logic [CNT_W-1:0] r_pend;
   logic             r_pend_vld;
   logic [CNT_W-1:0] w_pend_val;
   logic             w_apply;

   // A write in the same cycle as the boundary goes straight through
   assign w_pend_val = i_wr ? i_wr_div : r_pend;
   assign w_apply    = (i_wr || r_pend_vld) && (w_wrap || i_sync_clr || !w_active);
   assign w_restart  = i_sync_clr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div      <= DEF_DIV;
         r_pend     <= DEF_DIV;
         r_pend_vld <= 1'b0;
      end else begin
         if (i_wr) r_pend <= i_wr_div;
         if (w_apply) begin
            r_div      <= w_pend_val;
            r_pend_vld <= 1'b0;
         end else if (i_wr) begin
            r_pend_vld <= 1'b1;
         end
      end
   end
`else
   // Direct load truncates the running period, so the counter restarts with it
   assign w_restart = i_sync_clr || i_wr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div <= DEF_DIV;
      end else if (i_wr) begin
         r_div <= i_wr_div;
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
         r_sq   <= 1'b0;
      end else begin
         // A restart swallows the tick of the period it cuts short
         r_tick <= w_wrap && !w_restart;
         if (w_active) r_sq <= (r_cnt < w_half);
         if (w_restart) begin
            r_cnt <= '0;
         end else if (w_active) begin
            r_cnt <= w_wrap ? '0 : r_cnt + ONE;
         end
      end
   end

   assign o_tick = r_tick;
   assign o_sq   = r_sq;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH programmable clock-enable channels sharing one system clock.
// Latency: tick/sq one cycle after counter state; cfg_err one cycle after the write.
// Backpressure: none; one configuration write per cycle, out-of-range channel rejected.
// Ports: i_clk, i_rst_n (async active-low), i_ch_en per-channel run enable, i_sync_clr
//        phase alignment, i_cfg_we/i_cfg_ch/i_cfg_div divisor write, o_tick, o_sq, o_cfg_err.
// Build option DIV_SHADOW_EN: divisor writes take effect at the next period boundary.

module clock_divider_bank
   import clock_divider_pkg::*;
#(
   parameter int                      NUM_CH  = 3,
   parameter int                      CNT_W   = 24,
   parameter int                      CH_W    = 3,
   parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {24'(DIV_25MHZ), 24'(DIV_1KHZ), 24'(DIV_200HZ)}
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [NUM_CH-1:0] i_ch_en,
   input  logic              i_sync_clr,
   input  logic              i_cfg_we,
   input  logic [CH_W-1:0]   i_cfg_ch,
   input  logic [CNT_W-1:0]  i_cfg_div,
   output logic [NUM_CH-1:0] o_tick,
   output logic [NUM_CH-1:0] o_sq,
   output logic              o_cfg_err
);

   if (CH_W < clog2(NUM_CH)) begin : g_bad_ch_w
      $error("CH_W is too narrow to address NUM_CH channels");
   end

   localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

   logic w_ch_bad;
   logic r_cfg_err;

   // Extra MSB keeps the compare correct when 2**CH_W == NUM_CH
   assign w_ch_bad = ({1'b0, i_cfg_ch} >= NUM_CH_L);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic w_wr;
      assign w_wr = i_cfg_we && (i_cfg_ch == CH_W'(g));

      div_channel #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV[g*CNT_W +: CNT_W])
      ) u_ch (
         .i_clk      (i_clk),
         .i_rst_n    (i_rst_n),
         .i_en       (i_ch_en[g]),
         .i_sync_clr (i_sync_clr),
         .i_wr       (w_wr),
         .i_wr_div   (i_cfg_div),
         .o_tick     (o_tick[g]),
         .o_sq       (o_sq[g])
      );
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= i_cfg_we && w_ch_bad;
      end
   end

   assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank with shortened reset divisors (ch0=50, ch1=10, ch2=4).
// Latency: outputs sampled 1 ns after each rising edge; inputs change at the same point.
// Backpressure: n/a.

module tb_clock_divider_bank;

   localparam int NUM_CH = 3;
   localparam int CNT_W  = 24;
   localparam int CH_W   = 3;
   localparam logic [NUM_CH*CNT_W-1:0] TB_DEF = {24'd4, 24'd10, 24'd50};

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] ch_en;
   logic              sync_clr;
   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq;
   logic              cfg_err;

   always #5 clk = ~clk;

   clock_divider_bank #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .CH_W    (CH_W),
      .DEF_DIV (TB_DEF)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_ch_en    (ch_en),
      .i_sync_clr (sync_clr),
      .i_cfg_we   (cfg_we),
      .i_cfg_ch   (cfg_ch),
      .i_cfg_div  (cfg_div),
      .o_tick     (tick),
      .o_sq       (sq),
      .o_cfg_err  (cfg_err)
   );

   typedef struct {
      logic [2:0]  en;
      logic        sync;
      logic        we;
      logic [2:0]  ch;
      logic [23:0] div;
      logic        exp_tick2;
      logic        exp_sq2;
      logic        exp_err;
   } vec_t;

   vec_t vq[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   edge_n = 0;
   int   mark = 0;
   int   first_tick[NUM_CH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      edge_n++;
      for (int c = 0; c < NUM_CH; c++)
         if (tick[c] === 1'b1 && first_tick[c] < 0) first_tick[c] = edge_n;
   endtask

   task automatic add(input logic [2:0] en, input logic s, input logic w, input logic [2:0] c,
                      input logic [23:0] d, input logic t, input logic q, input logic e);
      vq.push_back('{en, s, w, c, d, t, q, e});
   endtask

   // Period between two consecutive ticks of a channel, bounded
   task automatic measure_period(input int c, input int exp, input string name);
      int n;
      n = 0;
      while (tick[c] !== 1'b1 && n < 200) begin cyc(); n++; end
      if (tick[c] !== 1'b1) begin
         chk({name, "_timeout"}, 32'd0, exp);
      end else begin
         n = 0;
         do begin cyc(); n++; end while (tick[c] !== 1'b1 && n < 200);
         chk(name, n, exp);
      end
   endtask

   initial begin
      #100_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] tm;
      logic [15:0] sm;
      logic [15:0] exp_tm;
      logic [15:0] exp_sm;
      logic        acc_t;
      logic        acc_s;
      int          n;

      for (int c = 0; c < NUM_CH; c++) first_tick[c] = -1;
      rst_n = 1'b0; ch_en = 3'b111; sync_clr = 1'b0;
      cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;

      repeat (2) cyc();
      chk("reset_tick", tick, 0);
      chk("reset_sq", sq, 0);
      chk("reset_err", cfg_err, 0);
      rst_n = 1'b1;

      // Per-edge expectations for ch2 (div 4) and cfg_err
      add(3'b111, 0, 0, 0, 0, 0, 1, 0);   // 1
      add(3'b111, 0, 0, 0, 0, 0, 1, 0);   // 2
      add(3'b111, 0, 0, 0, 0, 0, 0, 0);   // 3
      add(3'b111, 0, 0, 0, 0, 1, 0, 0);   // 4 first wrap
      add(3'b111, 0, 0, 0, 0, 0, 1, 0);   // 5
      add(3'b111, 0, 1, 3, 7, 0, 1, 1);   // 6 write to channel 3 rejected
      add(3'b111, 0, 0, 0, 0, 0, 0, 0);   // 7
      add(3'b111, 1, 0, 0, 0, 0, 0, 0);   // 8 sync_clr on the wrap cycle
      add(3'b111, 0, 0, 0, 0, 0, 1, 0);   // 9
      add(3'b111, 1, 0, 0, 0, 0, 1, 0);   // 10 sync_clr mid-period
      add(3'b111, 0, 0, 0, 0, 0, 1, 0);   // 11
      add(3'b111, 0, 0, 0, 0, 0, 1, 0);   // 12
      add(3'b111, 0, 0, 0, 0, 0, 0, 0);   // 13
      add(3'b111, 0, 0, 0, 0, 1, 0, 0);   // 14 four cycles after the clear
      add(3'b111, 0, 0, 0, 0, 0, 1, 0);   // 15
      for (int k = 0; k < 7; k++)
         add(3'b011, 0, 0, 0, 0, 0, 1, 0); // 16-22 ch2 disabled, sq held
      add(3'b111, 0, 0, 0, 0, 0, 1, 0);   // 23 resumes from held count 1
      add(3'b111, 0, 0, 0, 0, 0, 0, 0);   // 24
      add(3'b111, 0, 0, 0, 0, 1, 0, 0);   // 25
      add(3'b111, 0, 0, 0, 0, 0, 1, 0);   // 26

      for (int i = 0; i < vq.size(); i++) begin
         ch_en = vq[i].en; sync_clr = vq[i].sync; cfg_we = vq[i].we;
         cfg_ch = vq[i].ch; cfg_div = vq[i].div;
         cyc();
         chk($sformatf("row%0d_tick2", i + 1), tick[2], vq[i].exp_tick2);
         chk($sformatf("row%0d_sq2", i + 1), sq[2], vq[i].exp_sq2);
         chk($sformatf("row%0d_err", i + 1), cfg_err, vq[i].exp_err);
         if (i == 9) begin
            mark = edge_n;
            for (int c = 0; c < NUM_CH; c++) first_tick[c] = -1;
         end
      end
      ch_en = 3'b111; sync_clr = 1'b0; cfg_we = 1'b0;

      // Ticks after the sync clear are aligned to it; ch0/ch1 divisors survived the bad write
      while (edge_n < mark + 55) cyc();
      chk("align_ch1", first_tick[1], mark + 10);
      chk("align_ch0", first_tick[0], mark + 50);
      measure_period(1, 10, "period_ch1_default");
      measure_period(0, 50, "period_ch0_default");

      // Reprogram ch1 to 5 right after one of its ticks
      n = 0;
      while (tick[1] !== 1'b1 && n < 30) begin cyc(); n++; end
      chk("ch1_tick_found", tick[1], 1'b1);
      cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 24'd5;
      for (int k = 0; k < 16; k++) begin
         cyc();
         cfg_we = 1'b0;
         tm[k] = tick[1];
         sm[k] = sq[1];
      end
`ifdef DIV_SHADOW_EN
      exp_tm = 16'h4200;
      exp_sm = 16'h8C1F;
`else
      exp_tm = 16'h8420;
      exp_sm = 16'h18C7;
`endif
      chk("ch1_div5_tick_pattern", tm, exp_tm);
      chk("ch1_div5_sq_pattern", sm, exp_sm);
      measure_period(1, 5, "period_ch1_div5");

      // div = 0 parks ch2
      cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 24'd0;
      cyc();
      cfg_we = 1'b0;
      repeat (6) cyc();
      acc_t = 1'b0;
      repeat (5) begin cyc(); acc_t |= tick[2]; end
      chk("div0_tick_low", acc_t, 1'b0);

      // div = 1 holds tick high, sq low
      cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 24'd1;
      cyc();
      cfg_we = 1'b0;
      repeat (2) cyc();
      acc_t = 1'b1; acc_s = 1'b0;
      repeat (8) begin cyc(); acc_t &= tick[2]; acc_s |= sq[2]; end
      chk("div1_tick_high", acc_t, 1'b1);
      chk("div1_sq_low", acc_s, 1'b0);

      // Back-to-back writes: the later one wins
      cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 24'd7;
      cyc();
      cfg_div = 24'd4;
      cyc();
      cfg_we = 1'b0;
      measure_period(2, 4, "period_ch2_last_write");

      // Asynchronous reset pulse between edges
      n = 0;
      while (sq === '0 && n < 20) begin cyc(); n++; end
      chk("pre_reset_sq_active", (sq != '0), 1'b1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_tick", tick, 0);
      chk("async_reset_sq", sq, 0);
      chk("async_reset_err", cfg_err, 0);
      #2 rst_n = 1'b1;
      measure_period(2, 4, "post_reset_period_ch2");
      measure_period(1, 10, "post_reset_period_ch1");
      measure_period(0, 50, "post_reset_period_ch0");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
